// File: rtl/mac_array.sv
// Parallel signed MAC array: shared feature operand, per-lane coefficients, grouped accumulation
// with a registered multiply stage and rounded, narrowed output. Optional clamping via MAC_ARRAY_SATURATE_EN.
module mac_array #(
    parameter int NUM_LANES         = 16,
    parameter int A_WIDTH           = 16,
    parameter int B_WIDTH           = 16,
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int OUTPUT_SCALE      = 0,
    parameter int MAX_GROUP_LEN     = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    input  logic signed [A_WIDTH-1:0]            a,
    input  logic [NUM_LANES*B_WIDTH-1:0]         b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_LANES*OUTPUT_WIDTH-1:0]    out,
    output logic [NUM_LANES-1:0]                 out_sat,
    output logic [$clog2(MAX_GROUP_LEN+1)-1:0]   beat_cnt
);

    localparam int PW    = A_WIDTH + B_WIDTH;
    localparam int EW    = ACCUMULATOR_WIDTH + 1;
    localparam int CNT_W = $clog2(MAX_GROUP_LEN + 1);
    // Half-LSB rounding constant; collapses to zero when no scaling is applied.
    localparam logic [EW-1:0] RND = (EW'(1) << OUTPUT_SCALE) >> 1;

    typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

    state_t             r_state;
    logic               r_p_vld;
    logic               r_p_last;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               w_accept;

    assign in_ready  = (r_state == ACCUM) && !rst_in;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign beat_cnt  = r_beat_cnt;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state     <= ACCUM;
            r_p_vld     <= 1'b0;
            r_p_last    <= 1'b0;
            r_out_valid <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            r_p_vld  <= w_accept;
            r_p_last <= w_accept && in_last;
            if (w_accept && (r_beat_cnt != CNT_W'(MAX_GROUP_LEN)))
                r_beat_cnt <= r_beat_cnt + 1'b1;
            case (r_state)
                ACCUM: begin
                    if (w_accept && in_last)
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    // The last product is folded into the result on this same edge.
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_beat_cnt  <= '0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    logic signed [PW-1:0]                r_prod     [NUM_LANES];
    logic signed [ACCUMULATOR_WIDTH-1:0] r_acc      [NUM_LANES];
    logic [OUTPUT_WIDTH-1:0]             r_out_lane [NUM_LANES];
    logic                                r_sat      [NUM_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic signed [B_WIDTH-1:0]           w_b;
            logic signed [ACCUMULATOR_WIDTH-1:0] w_sum;
            logic signed [EW-1:0]                w_rnd;
            logic signed [EW-1:0]                w_scaled;
            logic [EW-OUTPUT_WIDTH:0]            w_hi;
            logic                                w_ovf;
            logic [OUTPUT_WIDTH-1:0]             w_val;
            logic                                w_sat;

            assign w_b      = b[gi*B_WIDTH +: B_WIDTH];
            assign w_sum    = r_acc[gi] + ACCUMULATOR_WIDTH'(r_prod[gi]);
            // One guard bit keeps the rounding add from wrapping at the top of the range.
            assign w_rnd    = EW'(w_sum) + $signed(RND);
            assign w_scaled = w_rnd >>> OUTPUT_SCALE;
            assign w_hi     = w_scaled[EW-1:OUTPUT_WIDTH-1];
            assign w_ovf    = !((&w_hi) || !(|w_hi));

`ifdef MAC_ARRAY_SATURATE_EN
            assign w_val = w_ovf ? (w_scaled[EW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}})
                                 : w_scaled[OUTPUT_WIDTH-1:0];
            assign w_sat = w_ovf;
`else
            assign w_val = w_scaled[OUTPUT_WIDTH-1:0];
            assign w_sat = 1'b0;
            logic w_unused_ovf;
            assign w_unused_ovf = w_ovf;
`endif

            always_ff @(posedge clk) begin
                if (rst_in) begin
                    r_prod[gi]     <= '0;
                    r_acc[gi]      <= '0;
                    r_out_lane[gi] <= '0;
                    r_sat[gi]      <= 1'b0;
                end else begin
                    if (w_accept)
                        r_prod[gi] <= PW'(a) * PW'(w_b);
                    if (r_p_vld) begin
                        if (r_p_last) begin
                            r_out_lane[gi] <= w_val;
                            r_sat[gi]      <= w_sat;
                            r_acc[gi]      <= '0;
                        end else begin
                            r_acc[gi]      <= w_sum;
                        end
                    end
                end
            end

            assign out[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] = r_out_lane[gi];
            assign out_sat[gi]                          = r_sat[gi];
        end
    endgenerate

endmodule

// File: doc/mac_array.md
Name: mac_array

Overview:
- Parametrised successor of the fixed 16-lane parallel MAC: NUM_LANES signed MAC lanes share one feature operand `a`, and each lane takes its own kernel coefficient from a packed vector.
- Adds a valid/ready input stream with group framing (in_last), a registered multiply stage, and rounded output scaling.
- Results are held with valid/ready backpressure and a per-group beat counter.
- Sits between the feature/kernel fetch logic and the output writeback in the convolution datapath.

Parameters:
- NUM_LANES, 16, number of parallel MAC lanes (>=1).
- A_WIDTH, 16, signed feature operand width.
- B_WIDTH, 16, signed coefficient width per lane.
- ACCUMULATOR_WIDTH, 32, signed accumulator width per lane (>= A_WIDTH+B_WIDTH).
- OUTPUT_WIDTH, 16, signed output width per lane.
- OUTPUT_SCALE, 0, arithmetic right shift applied to the accumulator at output (0..ACCUMULATOR_WIDTH-1).
- MAX_GROUP_LEN, 1024, beat counter saturation value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_last  input  1  beat is the final product of the current accumulation group.
- a  input  A_WIDTH  signed feature value, common to all lanes.
- b  input  NUM_LANES*B_WIDTH  signed coefficients; lane i at [i*B_WIDTH +: B_WIDTH].
- out_valid  output  1  result vector valid.
- out_ready  input  1  consumer accepts result.
- out  output  NUM_LANES*OUTPUT_WIDTH  signed results; lane i at [i*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- out_sat  output  NUM_LANES  per-lane saturation flag for the current result.
- beat_cnt  output  $clog2(MAX_GROUP_LEN+1)  beats accepted in the current group.

Behaviour:
- Reset: while rst_in=1, every register clears on the clock edge. in_ready=0, out_valid=0, out=0, out_sat=0, beat_cnt=0, accumulators=0, FSM=ACCUM.
- Reset mid-group discards the partial sums and any held result. The next group starts from 0.
- Beat accepted on the edge where in_valid && in_ready. in_valid, a, b and in_last are ignored when in_ready=0.
- Stage P: an accepted beat registers prod[i] = a*b[i] (full A_WIDTH+B_WIDTH signed) together with p_vld and p_last.
- Stage A: when p_vld, acc[i] <= acc[i] + sign-extended prod[i], wrapping two's complement at ACCUMULATOR_WIDTH.
- When p_last, the scaled sum (acc[i]+prod[i]) is written to out and acc[i] is cleared to 0 on the same edge.
- Scaling:
  - OUTPUT_SCALE=0 → value = sum.
  - Otherwise value = (sum + 2^(OUTPUT_SCALE-1)) >>> OUTPUT_SCALE (round half up).
  - value is narrowed to OUTPUT_WIDTH per the optional feature.
- FSM:
  - ACCUM: in_ready=1 (outside reset). An accepted beat with in_last=1 → FLUSH.
  - FLUSH: in_ready=0. Stage A completes the group, out_valid←1 → HOLD.
  - HOLD: in_ready=0; out, out_sat and out_valid held stable. out_valid && out_ready → out_valid←0, state ACCUM, so in_ready=1 in the following cycle.
- Latency: a last beat accepted in cycle c gives out_valid=1 from cycle c+2.
- Minimum group period is K+2 cycles for K beats; a 1-beat group (in_last on the first beat) is legal.
- beat_cnt: increments on each accepted beat and saturates at MAX_GROUP_LEN. It is cleared when the result handshake completes and keeps the final count during FLUSH/HOLD.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro MAC_ARRAY_SATURATE_EN.
- Defined: a scaled value outside the signed OUTPUT_WIDTH range clamps to the max/min, and out_sat[i]=1 for each clamped lane.
- Undefined: the low OUTPUT_WIDTH bits are taken (wrap) and out_sat is tied to 0.

Test Plan:
- Reset: hold rst_in 3 cycles with in_valid=1 → out_valid=0, out=0, in_ready=0 during reset; in_ready=1 in the first cycle after release; beat_cnt=0.
- Group: 3 beats a=2,3,-1 with b lane i=i+1, in_last on the third beat → out lane i=4*(i+1), out_valid two cycles after the last beat, beat_cnt=3, in_ready=0 until the handshake.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out stable and in_ready=0 throughout; out_ready=1 → next cycle out_valid=0, in_ready=1, beat_cnt=0.
- Rounding (OUTPUT_SCALE=4): 1-beat a=1, b lane0=24, lane1=-24 → out lane0=2, lane1=-1.
- Overflow: 2 beats a=32767, b=32767 on all lanes → with MAC_ARRAY_SATURATE_EN, out=32767 and out_sat all 1; without it, out=2 and out_sat=0.
- Reset mid-group: 2 beats a=5, b=5 accepted, then rst_in for 1 cycle, then 1-beat group a=1, b=5 → out lanes=5 (no leftover 50).
